// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_ctrl_pkg
// Description : Shared definitions for the 16-bit core pipeline control.
//               Holds the opcode constants used by the hazard logic and the
//               2-bit encoding of the hazard control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTING  = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter_16.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter_16
// Description : 16-bit event counter that saturates at 16'hFFFF.
// Ports       : clk     - clock
//               clr_i   - synchronous clear (highest priority)
//               en_i    - count one event this cycle
//               count_o - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_16 (
  input  logic        clk,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= 16'h0000;
    end else if (en_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'h0001;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline control for the 5-stage 16-bit core. Produces the
//               write-enable and flush of every stage register from load-use
//               hazards, taken branches, data-memory wait states and halt.
//               Priority: memory wait > load-use > taken branch > halt.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               id_*_i                   - instruction currently in ID
//               ex_op_i, ex_rd_i         - instruction currently in EX
//               dmem_req_i, dmem_ready_i - data memory handshake of MEM stage
//               wb_op_i                  - opcode currently in WB
//               *_we_o                   - stage register write enables
//               if_id_flush_o, id_ex_flush_o - load bubble instead of D
//               halted_o                 - registered halt status
//               stall_cnt_o, flush_cnt_o - performance counters
// Config      : HAZARD_CTRL_PERF_EN - enables the two saturating performance
//               counters; when undefined both counter outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter logic [3:0] OP_LW  = 4'h8,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs_i,
  input  logic [3:0]  id_rt_i,
  input  logic        id_rs_used_i,
  input  logic        id_rt_used_i,
  input  logic [3:0]  id_op_i,
  input  logic        id_br_taken_i,
  input  logic [3:0]  ex_op_i,
  input  logic [3:0]  ex_rd_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  input  logic [3:0]  wb_op_i,
  output logic        pc_we_o,
  output logic        if_id_we_o,
  output logic        id_ex_we_o,
  output logic        ex_mem_we_o,
  output logic        mem_wb_we_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        halted_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  ctrl_state_e state_q, state_d;
  ctrl_state_e eff_state;
  logic        halt_pend_q, halt_pend_d;
  logic        halted_q;
  logic        lu, mw;

  // R0 is hardwired, so a load targeting it can never create a dependency.
  assign lu = (ex_op_i == OP_LW) && (ex_rd_i != 4'd0) &&
              ((id_rs_used_i && (id_rs_i == ex_rd_i)) ||
               (id_rt_used_i && (id_rt_i == ex_rd_i)));
  assign mw = dmem_req_i && !dmem_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      halted_q    <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d       = state_q;
    halt_pend_d   = halt_pend_q;
    pc_we_o       = 1'b1;
    if_id_we_o    = 1'b1;
    id_ex_we_o    = 1'b1;
    ex_mem_we_o   = 1'b1;
    mem_wb_we_o   = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;

    // MEM_WAIT only remembers a freeze; once memory completes, the cycle is
    // handled as the state the freeze interrupted (tracked by halt_pend_q).
    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = halt_pend_q ? HALTING : RUN;
    end

    if (mw && (eff_state != HALTED)) begin
      pc_we_o     = 1'b0;
      if_id_we_o  = 1'b0;
      id_ex_we_o  = 1'b0;
      ex_mem_we_o = 1'b0;
      mem_wb_we_o = 1'b0;
      state_d     = MEM_WAIT;
    end else begin
      case (eff_state)
        RUN: begin
          state_d = RUN;
          if (lu) begin
            // Hold PC and IF/ID, send one bubble into EX; a branch in ID
            // re-resolves next cycle.
            pc_we_o       = 1'b0;
            if_id_we_o    = 1'b0;
            id_ex_flush_o = 1'b1;
          end else if (id_br_taken_i) begin
            if_id_flush_o = 1'b1;
          end else if (id_op_i == OP_HLT) begin
            pc_we_o       = 1'b0;
            if_id_flush_o = 1'b1;
            state_d       = HALTING;
            halt_pend_d   = 1'b1;
          end
        end
        HALTING: begin
          // Drain the pipeline behind HLT until it reaches WB.
          pc_we_o       = 1'b0;
          if_id_flush_o = 1'b1;
          state_d       = (wb_op_i == OP_HLT) ? HALTED : HALTING;
        end
        HALTED: begin
          pc_we_o     = 1'b0;
          if_id_we_o  = 1'b0;
          id_ex_we_o  = 1'b0;
          ex_mem_we_o = 1'b0;
          mem_wb_we_o = 1'b0;
          state_d     = HALTED;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    // During reset every stage loads a bubble.
    if (rst) begin
      pc_we_o       = 1'b1;
      if_id_we_o    = 1'b1;
      id_ex_we_o    = 1'b1;
      ex_mem_we_o   = 1'b1;
      mem_wb_we_o   = 1'b1;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end
  end

  assign halted_o = halted_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic stall_ev;
  logic flush_ev;

  assign stall_ev = !pc_we_o && (state_q != HALTED);
  assign flush_ev = if_id_flush_o || id_ex_flush_o;

  sat_counter_16 u_stall_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .en_i    (stall_ev),
    .count_o (stall_cnt_o)
  );

  sat_counter_16 u_flush_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .en_i    (flush_ev),
    .count_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = 16'h0000;
  assign flush_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire
